window_flush_ctrl: RTL and testbench

Frame sequencer placed directly in front of the line-buffer window generator. It accepts the pixel stream from upstream and tracks raster position against a fixed frame size. After the last pixel of a frame it back-pressures upstream and injects padding lines so the window generator's delay lines drain the final rows. It forwards a registered stream to the window generator, which cannot stall.

---
 rtl/window_flush_ctrl.sv | 118 +++++++++++
 tb/tb_window_flush_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/window_flush_ctrl.sv
// Frame sequencer ahead of the line-buffer window generator: tracks raster
// position, then back-pressures upstream and injects pad lines to drain the window.
module window_flush_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int IMG_WIDTH     = 1920,
  parameter int IMG_HEIGHT    = 1080,
  parameter int WINDOWS_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [7:0]            in_user,
  input  logic                  in_valid,
  output logic                  out_ready,
  output logic [DATA_WIDTH-1:0] win_data,
  output logic [7:0]            win_user,
  output logic                  win_valid,
  output logic [15:0]           x_cnt,
  output logic [15:0]           y_cnt,
  output logic                  frame_done,
  output logic                  sof_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int unsigned FLUSH_LEN = (WINDOWS_WIDTH - 1) * IMG_WIDTH;
  localparam int          FCW       = $clog2(FLUSH_LEN + 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_LEN - 1);
  localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

  logic [1:0]     state;
  logic [FCW-1:0] flush_cnt;
  logic [15:0]    nx, ny;
  logic           accept;

  assign out_ready = (state == S_IDLE) || (state == S_PASS);
  assign accept    = in_valid & out_ready;

  // Raster position of the pixel that follows the last forwarded one.
  always_comb begin
    nx = x_cnt + 16'd1;
    ny = y_cnt;
    if (x_cnt == X_LAST) begin
      nx = '0;
      ny = y_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      flush_cnt  <= '0;
      win_data   <= '0;
      win_user   <= '0;
      win_valid  <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && in_user[0]) begin
            win_data  <= in_data;
            win_user  <= in_user;
            win_valid <= 1'b1;
            x_cnt     <= '0;
            y_cnt     <= '0;
            state     <= S_PASS;
          end
        end
        S_PASS: begin
          if (accept) begin
            win_data  <= in_data;
            win_user  <= in_user;
            win_valid <= 1'b1;
            // (0,0) is always consumed in IDLE, so any SOF seen here is mid-frame.
            if (in_user[0]) begin
              sof_err <= 1'b1;
              x_cnt   <= '0;
              y_cnt   <= '0;
            end else begin
              x_cnt <= nx;
              y_cnt <= ny;
              if (nx == X_LAST && ny == Y_LAST) begin
                flush_cnt <= '0;
                state     <= S_FLUSH;
              end
            end
          end
        end
        S_FLUSH: begin
          win_data  <= PAD_VALUE;
          win_user  <= '0;
          win_valid <= 1'b1;
          x_cnt     <= nx;
          y_cnt     <= ny;
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == FLUSH_LAST) state <= S_DONE;
        end
        default: begin
          frame_done <= 1'b1;
          x_cnt      <= '0;
          y_cnt      <= '0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_flush_ctrl.sv
// Directed bench for window_flush_ctrl with a 4x3 frame, 3-wide window and 16'hFFFF padding.
module tb_window_flush_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic [7:0]  in_user;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] win_data;
  logic [7:0]  win_user;
  logic        win_valid;
  logic [15:0] x_cnt;
  logic [15:0] y_cnt;
  logic        frame_done;
  logic        sof_err;

  int tests = 0;
  int fails = 0;

  window_flush_ctrl #(
    .DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(3), .WINDOWS_WIDTH(3), .PAD_VALUE(16'hFFFF)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_user(in_user), .in_valid(in_valid),
    .out_ready(out_ready), .win_data(win_data), .win_user(win_user), .win_valid(win_valid),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic sof);
    in_data  = d;
    in_user  = {7'b0, sof};
    in_valid = 1'b1;
    step();
  endtask

  // Steps until frame_done (bounded), counting pad pixels seen on the way.
  task automatic wait_done(output int pads, output bit found);
    pads  = 0;
    found = 0;
    for (int n = 0; n < 30 && !found; n++) begin
      step();
      if (win_valid && win_data == 16'hFFFF) pads++;
      if (frame_done) found = 1;
    end
  endtask

  int  pads;
  bit  found;
  int  low_cnt;
  int  done_cnt;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_user = '0;
    step(); step();
    check("rst_win_valid", 32'(win_valid), 0);
    check("rst_win_data", 32'(win_data), 0);
    check("rst_win_user", 32'(win_user), 0);
    check("rst_x", 32'(x_cnt), 0);
    check("rst_y", 32'(y_cnt), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_sof_err", 32'(sof_err), 0);
    check("rst_ready", 32'(out_ready), 1);
    reset = 1'b0;

    // Non-SOF pixels in IDLE are dropped.
    for (int i = 0; i < 3; i++) begin
      send(16'd7, 1'b0);
      check("idle_drop_valid", 32'(win_valid), 0);
      check("idle_drop_xy", {x_cnt, y_cnt}, 0);
    end

    // Full back-to-back frame followed by the flush.
    low_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      send(16'(i), i == 1);
      check("frm_valid", 32'(win_valid), 1);
      check("frm_data", 32'(win_data), 32'(i));
      check("frm_user", 32'(win_user), (i == 1) ? 1 : 0);
      check("frm_x", 32'(x_cnt), 32'((i - 1) % 4));
      check("frm_y", 32'(y_cnt), 32'((i - 1) / 4));
      check("frm_ready", 32'(out_ready), (i == 12) ? 0 : 1);
      if (!out_ready) low_cnt++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("pad_valid", 32'(win_valid), 1);
      check("pad_data", 32'(win_data), 32'hFFFF);
      check("pad_user", 32'(win_user), 0);
      check("pad_x", 32'(x_cnt), 32'(k % 4));
      check("pad_y", 32'(y_cnt), 32'(3 + k / 4));
      check("pad_done", 32'(frame_done), 0);
      if (!out_ready) low_cnt++;
    end
    step();
    check("done_pulse", 32'(frame_done), 1);
    check("done_valid", 32'(win_valid), 0);
    check("done_ready", 32'(out_ready), 1);
    check("done_xy", {x_cnt, y_cnt}, 0);
    check("ready_low_cycles", 32'(low_cnt), 9);
    step();
    check("done_once", 32'(frame_done), 0);

    // Same frame with in_valid toggling.
    for (int i = 1; i <= 12; i++) begin
      send(16'(i), i == 1);
      check("tog_valid", 32'(win_valid), 1);
      check("tog_data", 32'(win_data), 32'(i));
      check("tog_xy", {x_cnt, y_cnt}, {16'((i - 1) % 4), 16'((i - 1) / 4)});
      in_valid = 1'b0;
      if (i < 12) begin
        step();
        check("tog_gap_valid", 32'(win_valid), 0);
        check("tog_gap_hold", {win_data, x_cnt}, {16'(i), 16'((i - 1) % 4)});
      end
    end
    wait_done(pads, found);
    check("tog_done_found", 32'(found), 1);
    check("tog_pads", 32'(pads), 8);

    // SOF mid-frame at (1,1) restarts the counters and flags sof_err.
    for (int i = 1; i <= 5; i++) send(16'(i), i == 1);
    check("pre_sof_err", 32'(sof_err), 0);
    send(16'd6, 1'b1);
    check("sof_err_set", 32'(sof_err), 1);
    check("sof_restart_xy", {x_cnt, y_cnt}, 0);
    check("sof_data", 32'(win_data), 6);
    for (int j = 1; j <= 11; j++) begin
      send(16'(100 + j), 1'b0);
      check("sof_ready", 32'(out_ready), (j == 11) ? 0 : 1);
    end
    in_valid = 1'b0;
    check("sof_last_xy", {x_cnt, y_cnt}, {16'd3, 16'd2});
    wait_done(pads, found);
    check("sof_done_found", 32'(found), 1);
    check("sof_err_sticky", 32'(sof_err), 1);

    // Reset on the 4th flush cycle aborts the flush.
    for (int i = 1; i <= 12; i++) send(16'(i), i == 1);
    in_valid = 1'b0;
    step(); step(); step();
    check("abort_pre_pad", 32'(win_data), 32'hFFFF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_valid", 32'(win_valid), 0);
    check("abort_ready", 32'(out_ready), 1);
    check("abort_xy", {x_cnt, y_cnt}, 0);
    check("abort_sof_err", 32'(sof_err), 0);
    done_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (frame_done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 0);
    for (int i = 1; i <= 12; i++) send(16'(200 + i), i == 1);
    in_valid = 1'b0;
    check("post_abort_last", {win_data, x_cnt, y_cnt}, {16'd212, 16'd3, 16'd2});
    wait_done(pads, found);
    check("post_abort_found", 32'(found), 1);
    check("post_abort_pads", 32'(pads), 8);

    // in_valid held high with a SOF pixel through flush and DONE.
    for (int i = 1; i <= 12; i++) send(16'(i), i == 1);
    in_data = 16'h0055; in_user = 8'h01; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("hold_pad_data", 32'(win_data), 32'hFFFF);
      check("hold_ready", 32'(out_ready), 0);
    end
    step();
    check("hold_done", 32'(frame_done), 1);
    check("hold_done_valid", 32'(win_valid), 0);
    step();
    in_valid = 1'b0;
    check("hold_accept_valid", 32'(win_valid), 1);
    check("hold_accept_data", {win_data, win_user}, {16'h0055, 8'h01});
    check("hold_accept_xy", {x_cnt, y_cnt}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
